// File: rtl/counter_seq_ctrl_pkg.sv
// Shared state encoding and direction constants for the lap sequencer.
package counter_seq_ctrl_pkg;
  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_CLEAR = 2'd1;
  localparam state_t S_RUN   = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
endpackage

// File: rtl/counter_seq_lap.sv
// Lap bookkeeping: latched lap target and laps-completed counter.
// o_last_lap flags that the next increment reaches the programmed lap count.
module counter_seq_lap #(
  parameter int lap_bits = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [lap_bits-1:0] i_laps,
  input  logic                i_zero,
  input  logic                i_inc,
  output logic [lap_bits-1:0] o_lap_cnt,
  output logic                o_last_lap
);
  logic [lap_bits-1:0] r_laps;
  logic [lap_bits-1:0] r_lap_cnt;
  logic [lap_bits-1:0] w_lap_nxt;

  assign w_lap_nxt = r_lap_cnt + lap_bits'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_laps    <= '0;
      r_lap_cnt <= '0;
    end else begin
      if (i_load) r_laps <= i_laps;
      if (i_zero)     r_lap_cnt <= '0;
      else if (i_inc) r_lap_cnt <= w_lap_nxt;
    end
  end

  assign o_lap_cnt  = r_lap_cnt;
  assign o_last_lap = (w_lap_nxt == r_laps);
endmodule

// File: rtl/counter_seq_ctrl.sv
// Drives an external up/down counter through a programmed number of laps:
// clear, count to the terminal value, repeat, then pulse done.
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int bits     = 4,
  parameter int lap_bits = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                pause,
  input  logic                dir_in,
  input  logic [bits-1:0]     target,
  input  logic [lap_bits-1:0] laps,
  input  logic [bits-1:0]     count,
  output logic                cnt_clr,
  output logic                cnt_en,
  output logic                cnt_sel,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [lap_bits-1:0] lap_cnt
);
  state_t          r_state;
  state_t          w_state_nxt;
  logic [bits-1:0] r_term;
  logic            r_dir;
  logic            r_err;
  logic            w_cfg_ok;
  logic            w_accept;
  logic            w_reject;
  logic            w_term_hit;
  logic            w_lap_inc;
  logic            w_last_lap;

  assign w_cfg_ok   = (target != '0) && (laps != '0);
  assign w_accept   = (r_state == S_IDLE) && start && w_cfg_ok;
  assign w_reject   = (r_state == S_IDLE) && start && !w_cfg_ok;
  assign w_term_hit = (count == r_term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_term  <= '0;
      r_dir   <= DIR_UP;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_reject;
      if (w_accept) begin
        r_dir  <= dir_in;
        // Down laps end at the two's-complement image of the target.
        r_term <= (dir_in == DIR_DN) ? (bits'(0) - target) : target;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_CLEAR;
      S_CLEAR: w_state_nxt = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)           w_state_nxt = S_IDLE;
        else if (w_term_hit) w_state_nxt = w_last_lap ? S_DONE : S_CLEAR;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_clr   = (r_state == S_CLEAR) && !abort;
    cnt_en    = (r_state == S_RUN) && !w_term_hit && !pause && !abort;
    w_lap_inc = (r_state == S_RUN) && w_term_hit && !abort;
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE) && !abort;
  end

  assign cnt_sel = r_dir;
  assign err     = r_err;

  counter_seq_lap #(.lap_bits(lap_bits)) u_lap (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept),
    .i_laps    (laps),
    .i_zero    (w_accept),
    .i_inc     (w_lap_inc),
    .o_lap_cnt (lap_cnt),
    .o_last_lap(w_last_lap)
  );
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: external counter model, table vectors, corner sequences, random runs.
module tb_counter_seq_ctrl;
  localparam int BITS = 4;
  localparam int LB   = 4;
  localparam int NC   = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic            start, abort, pause, dir_in;
  logic [BITS-1:0] target;
  logic [LB-1:0]   laps;
  logic [BITS-1:0] count;
  logic            cnt_clr, cnt_en, cnt_sel, busy, done, err;
  logic [LB-1:0]   lap_cnt;

  int checks   = 0;
  int failures = 0;

  logic            en_log [NC], clr_log [NC], busy_log [NC], done_log [NC], err_log [NC], sel_log [NC];
  logic [BITS-1:0] cnt_log [NC];
  logic            e_en [NC], e_clr [NC], e_busy [NC], e_done [NC];

  counter_seq_ctrl #(.bits(BITS), .lap_bits(LB)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
    .dir_in(dir_in), .target(target), .laps(laps), .count(count),
    .cnt_clr(cnt_clr), .cnt_en(cnt_en), .cnt_sel(cnt_sel), .busy(busy),
    .done(done), .err(err), .lap_cnt(lap_cnt)
  );

  always #5 clk = ~clk;

  // The counter the sequencer is meant to drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          count <= '0;
    else if (cnt_clr) count <= '0;
    else if (cnt_en)  count <= cnt_sel ? BITS'(count - 1'b1) : BITS'(count + 1'b1);
  end

  initial begin
    #300000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Entered just after a rising edge; cycle 0 is the one presenting start.
  task automatic do_run(input logic d, input int t, input int l, input logic [NC-1:0] pm,
                        input int abort_cyc, input int restart_cyc, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      start  = (c == 0) || (c == restart_cyc);
      dir_in = d;
      target = (c == restart_cyc) ? '0 : BITS'(t);
      laps   = LB'(l);
      pause  = pm[c];
      abort  = (c == abort_cyc);
      @(negedge clk);
      en_log[c] = cnt_en;  clr_log[c] = cnt_clr; busy_log[c] = busy;
      done_log[c] = done;  err_log[c] = err;     sel_log[c] = cnt_sel;
      cnt_log[c] = count;
      @(posedge clk); #1;
    end
    start = 0; pause = 0; abort = 0;
  endtask

  // Expected schedule from the lap rules: one clear cycle, target counting
  // cycles (each delayed by any pause), one terminal cycle; done after the last lap.
  task automatic build_exp(input int t, input int l, input logic [NC-1:0] pm,
                           input bit acc, output int dn);
    int c;
    for (int k = 0; k < NC; k++) begin
      e_en[k] = 0; e_clr[k] = 0; e_busy[k] = 0; e_done[k] = 0;
    end
    dn = -1;
    if (acc) begin
      c = 1;
      for (int lp = 0; lp < l; lp++) begin
        if (c < NC) e_clr[c] = 1;
        c++;
        for (int s = 0; s < t; s++) begin
          while (c < NC - 1 && pm[c]) c++;
          if (c < NC) e_en[c] = 1;
          c++;
        end
        c++;
      end
      dn = c;
      if (c < NC) e_done[c] = 1;
      for (int k = 1; k <= c && k < NC; k++) e_busy[k] = 1;
    end
  endtask

  function automatic int sched_mism(input int ncyc, input logic d, input bit acc);
    int m = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (en_log[c] !== e_en[c])     m++;
      if (clr_log[c] !== e_clr[c])   m++;
      if (busy_log[c] !== e_busy[c]) m++;
      if (done_log[c] !== e_done[c]) m++;
      if (acc && c >= 1 && sel_log[c] !== d) m++;
      if (err_log[c] !== (!acc && c == 1)) m++;
    end
    return m;
  endfunction

  function automatic int first_done(input int ncyc);
    for (int c = 0; c < ncyc; c++) if (done_log[c]) return c;
    return -1;
  endfunction

  function automatic int n_pulses(input int ncyc, input bit which_err);
    int n = 0;
    for (int c = 0; c < ncyc; c++) n += which_err ? int'(err_log[c]) : int'(done_log[c]);
    return n;
  endfunction

  typedef struct {
    logic d; int t; int l; int exp_done; int exp_lap; logic exp_sel; int exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int dn, nc, mism;
    logic [NC-1:0] pm;
    logic d;
    int t, l;

    vecs[0] = '{1'b0, 3, 2, 11, 2, 1'b0, 0};
    vecs[1] = '{1'b1, 3, 2, 11, 2, 1'b1, 0};
    vecs[2] = '{1'b0, 0, 2, -1, 2, 1'b1, 1};
    vecs[3] = '{1'b0, 5, 0, -1, 2, 1'b1, 1};
    vecs[4] = '{1'b0, 1, 1, 4, 1, 1'b0, 0};
    vecs[5] = '{1'b0, 15, 1, 18, 1, 1'b0, 0};
    vecs[6] = '{1'b1, 7, 3, 28, 3, 1'b1, 0};
    vecs[7] = '{1'b0, 2, 15, 61, 15, 1'b0, 0};

    rst = 1; start = 0; abort = 0; pause = 0; dir_in = 0; target = '0; laps = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);     chk("rst_err", err, 0);
    chk("rst_en", cnt_en, 0);   chk("rst_clr", cnt_clr, 0);   chk("rst_sel", cnt_sel, 0);
    chk("rst_lap", lap_cnt, 0);
    rst = 0;
    @(posedge clk); #1;

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      nc = (vecs[i].exp_done < 0) ? 4 : vecs[i].exp_done + 3;
      do_run(vecs[i].d, vecs[i].t, vecs[i].l, '0, -1, -1, nc);
      build_exp(vecs[i].t, vecs[i].l, '0, vecs[i].exp_done >= 0, dn);
      chk($sformatf("vec%0d_done_cyc", i), first_done(nc), vecs[i].exp_done);
      chk($sformatf("vec%0d_err_pulses", i), n_pulses(nc, 1), vecs[i].exp_err);
      chk($sformatf("vec%0d_sched", i), sched_mism(nc, vecs[i].d, vecs[i].exp_done >= 0), 0);
      chk($sformatf("vec%0d_lap", i), lap_cnt, vecs[i].exp_lap);
      chk($sformatf("vec%0d_sel", i), cnt_sel, vecs[i].exp_sel);
      chk($sformatf("vec%0d_idle", i), busy, 0);
      if (i == 1) begin
        chk("down_cnt_c2", cnt_log[2], 0);  chk("down_cnt_c3", cnt_log[3], 15);
        chk("down_cnt_c4", cnt_log[4], 14); chk("down_cnt_c5", cnt_log[5], 13);
      end
    end

    // Pause for two cycles stretches the run by two
    pm = '0; pm[3] = 1; pm[4] = 1;
    do_run(1'b0, 3, 1, pm, -1, -1, 11);
    build_exp(3, 1, pm, 1, dn);
    chk("pause_done_cyc", first_done(11), 8);
    chk("pause_en_c3", en_log[3], 0);
    chk("pause_en_c4", en_log[4], 0);
    chk("pause_sched", sched_mism(11, 1'b0, 1), 0);

    // Abort mid-run
    do_run(1'b0, 5, 3, '0, 4, -1, 10);
    chk("abort_en_c3", en_log[3], 1);
    chk("abort_en_c4", en_log[4], 0);
    chk("abort_busy_c5", busy_log[5], 0);
    chk("abort_done", n_pulses(10, 0), 0);
    chk("abort_lap", lap_cnt, 0);

    // Start together with abort in IDLE is accepted
    do_run(1'b0, 2, 1, '0, 0, -1, 8);
    chk("startabort_busy_c1", busy_log[1], 1);
    chk("startabort_done_cyc", first_done(8), 5);

    // Start (with a bad target) while busy is ignored
    do_run(1'b0, 3, 2, '0, -1, 3, 14);
    build_exp(3, 2, '0, 1, dn);
    chk("busystart_done_cyc", first_done(14), 11);
    chk("busystart_err", n_pulses(14, 1), 0);
    chk("busystart_sched", sched_mism(14, 1'b0, 1), 0);

    // Asynchronous reset in the second lap
    do_run(1'b1, 2, 3, '0, -1, -1, 8);
    chk("prerst_lap", lap_cnt, 1);
    chk("prerst_busy", busy, 1);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);   chk("arst_en", cnt_en, 0);   chk("arst_clr", cnt_clr, 0);
    chk("arst_sel", cnt_sel, 0); chk("arst_done", done, 0);   chk("arst_err", err, 0);
    chk("arst_lap", lap_cnt, 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // Randomized runs against the schedule model
    for (int r = 0; r < 20; r++) begin
      d = 1'($urandom_range(1));
      t = $urandom_range(7, 1);
      l = $urandom_range(5, 1);
      pm = '0;
      for (int k = 2; k < 100; k++) pm[k] = ($urandom_range(3) == 0);
      build_exp(t, l, pm, 1, dn);
      nc = (dn + 3 < NC) ? dn + 3 : NC;
      do_run(d, t, l, pm, -1, -1, nc);
      chk($sformatf("rnd%0d_done_cyc", r), first_done(nc), (dn < NC) ? dn : -1);
      chk($sformatf("rnd%0d_sched", r), sched_mism(nc, d, 1), 0);
      chk($sformatf("rnd%0d_lap", r), lap_cnt, l);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
